// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit constants: reset PC, instruction-memory window and fetch exception codes.
// The IM window check is only present when IFU_FETCH_EXC_EN is defined.
package ifu_fetch_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

`ifdef IFU_FETCH_EXC_EN
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;
  localparam logic [31:0] IM_LIMIT = IM_BASE + 32'(IM_WORDS * 4);
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_NONE = 5'd0;

  // Word-aligned and inside [IM_BASE, IM_LIMIT).
  function automatic logic pc_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= IM_BASE) && (pc < IM_LIMIT);
  endfunction
`endif

endpackage

// File: rtl/ifu_pc_gen.sv
// PC register with a one-entry pending-redirect slot; next PC is ready the edge after advance.
// While decode stalls the PC holds and the latest redirect is parked until the stall ends or a flush.
module ifu_pc_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);
  import ifu_fetch_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  always_comb begin
    pc_d      = pc_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    if (flush || advance) begin
      pend_v_d = 1'b0;
      if (redirect_valid) begin
        pc_d = redirect_pc;
      end else if (pend_v_q) begin
        pc_d = pend_pc_q;
      end else if (!flush) begin
        // A flush re-fetches the current PC instead of stepping past it.
        pc_d = pc_q + 32'd4;
      end
    end else if (redirect_valid) begin
      pend_v_d  = 1'b1;
      pend_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= PC_RESET;
      pend_v_q  <= 1'b0;
      pend_pc_q <= 32'h0;
    end else begin
      pc_q      <= pc_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: PC drives IM combinationally, instruction lands in F/D one edge later; F/D holds while d_ready=0.
// IFU_FETCH_EXC_EN adds an address check that replaces bad fetches with a nop tagged AdEL on fd_exc.
module ifu_fetch (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  input  logic        d_ready,
  output logic        fd_valid,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
`ifdef IFU_FETCH_EXC_EN
  output logic [4:0]  fd_exc,
`endif
  output logic [31:0] fd_pc8
);
  import ifu_fetch_pkg::*;

  logic [31:0] pc;
  logic        advance;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;
`ifdef IFU_FETCH_EXC_EN
  logic [4:0]  fd_exc_q, fd_exc_d;
`endif

  assign advance = d_ready | ~fd_valid_q;

  ifu_pc_gen u_pc_gen (
    .clk            (clk),
    .reset_n        (reset_n),
    .advance        (advance),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  always_comb begin
    fd_valid_d = fd_valid_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
`ifdef IFU_FETCH_EXC_EN
    fd_exc_d   = fd_exc_q;
`endif
    if (flush) begin
      fd_valid_d = 1'b0;
      fd_instr_d = 32'h0;
`ifdef IFU_FETCH_EXC_EN
      fd_exc_d   = 5'd0;
`endif
    end else if (advance) begin
      // The delay-slot instruction is captured even when a redirect is arriving.
      fd_valid_d = 1'b1;
      fd_instr_d = im_rdata;
      fd_pc_d    = pc;
`ifdef IFU_FETCH_EXC_EN
      fd_exc_d   = EXC_NONE;
      if (!pc_legal(pc)) begin
        fd_instr_d = 32'h0;
        fd_exc_d   = EXC_ADEL;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fd_valid_q <= 1'b0;
      fd_instr_q <= 32'h0;
      fd_pc_q    <= 32'h0;
`ifdef IFU_FETCH_EXC_EN
      fd_exc_q   <= 5'd0;
`endif
    end else begin
      fd_valid_q <= fd_valid_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
`ifdef IFU_FETCH_EXC_EN
      fd_exc_q   <= fd_exc_d;
`endif
    end
  end

  assign im_addr  = pc;
  assign fd_valid = fd_valid_q;
  assign fd_instr = fd_instr_q;
  assign fd_pc    = fd_pc_q;
  assign fd_pc8   = fd_pc_q + 32'd8;
`ifdef IFU_FETCH_EXC_EN
  assign fd_exc   = fd_exc_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a vector table drives per-cycle inputs, expectations go through a queue,
// plus a hand-written reset-during-pending-redirect sequence.
module tb_ifu_fetch;

  localparam logic [31:0] IM_KEY = 32'h5A5A_A5A5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        d_ready;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  logic [31:0] fd_pc8;
`ifdef IFU_FETCH_EXC_EN
  logic [4:0]  fd_exc;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Instruction memory model: every word is a recognisable function of its address.
  assign im_rdata = im_addr ^ IM_KEY;

  ifu_fetch dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .d_ready        (d_ready),
    .fd_valid       (fd_valid),
    .fd_instr       (fd_instr),
    .fd_pc          (fd_pc),
`ifdef IFU_FETCH_EXC_EN
    .fd_exc         (fd_exc),
`endif
    .fd_pc8         (fd_pc8)
  );

  typedef struct {
    logic        dr;
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } exp_t;

  vec_t tbl[28];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a < 32'h0000_7000);
  endfunction

  function automatic logic [31:0] exp_instr(input logic v, input logic [31:0] pc);
    if (!v) return 32'h0;
`ifdef IFU_FETCH_EXC_EN
    if (!addr_ok(pc)) return 32'h0;
`endif
    return pc ^ IM_KEY;
  endfunction

  task automatic check_state(input string tag, input logic [31:0] e_addr, input logic e_v,
                             input logic [31:0] e_pc);
    chk({tag, " im_addr"},  im_addr,  e_addr);
    chk({tag, " fd_valid"}, {31'h0, fd_valid}, {31'h0, e_v});
    chk({tag, " fd_pc"},    fd_pc,    e_pc);
    chk({tag, " fd_pc8"},   fd_pc8,   e_pc + 32'd8);
    chk({tag, " fd_instr"}, fd_instr, exp_instr(e_v, e_pc));
`ifdef IFU_FETCH_EXC_EN
    chk({tag, " fd_exc"}, {27'h0, fd_exc},
        (e_v && !addr_ok(e_pc)) ? 32'd4 : 32'd0);
`endif
  endtask

  initial begin
    //          dr    rv    rpc            fl    im_addr        v     fd_pc
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_3004, 1'b1, 32'h0000_3000};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_3008, 1'b1, 32'h0000_3004};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_3008, 1'b1, 32'h0000_3004};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_3008, 1'b1, 32'h0000_3004};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_300C, 1'b1, 32'h0000_3008};
    tbl[5]  = '{1'b1, 1'b1, 32'h0000_3100, 1'b0, 32'h0000_3100, 1'b1, 32'h0000_300C};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_3104, 1'b1, 32'h0000_3100};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_3200, 1'b0, 32'h0000_3104, 1'b1, 32'h0000_3100};
    tbl[8]  = '{1'b0, 1'b1, 32'h0000_3300, 1'b0, 32'h0000_3104, 1'b1, 32'h0000_3100};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_3300, 1'b1, 32'h0000_3104};
    tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_3304, 1'b1, 32'h0000_3300};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_4180, 1'b1, 32'h0000_4180, 1'b0, 32'h0000_3300};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_4184, 1'b1, 32'h0000_4180};
    tbl[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_4184, 1'b0, 32'h0000_4180};
    tbl[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_4188, 1'b1, 32'h0000_4184};
    tbl[15] = '{1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0000_4188, 1'b1, 32'h0000_4184};
    tbl[16] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_5000, 1'b0, 32'h0000_4184};
    tbl[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_5004, 1'b1, 32'h0000_5000};
    tbl[18] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_5004};
    tbl[19] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
    tbl[20] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0004, 1'b1, 32'h0000_0000};
    tbl[21] = '{1'b1, 1'b1, 32'h0000_3002, 1'b0, 32'h0000_3002, 1'b1, 32'h0000_0004};
    tbl[22] = '{1'b1, 1'b1, 32'h0000_2FFC, 1'b0, 32'h0000_2FFC, 1'b1, 32'h0000_3002};
    tbl[23] = '{1'b1, 1'b1, 32'h0000_3004, 1'b0, 32'h0000_3004, 1'b1, 32'h0000_2FFC};
    tbl[24] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_3008, 1'b1, 32'h0000_3004};
    tbl[25] = '{1'b1, 1'b1, 32'h0000_6FFC, 1'b0, 32'h0000_6FFC, 1'b1, 32'h0000_3008};
    tbl[26] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_7000, 1'b1, 32'h0000_6FFC};
    tbl[27] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_7004, 1'b1, 32'h0000_7000};

    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    flush          = 1'b0;
    d_ready        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 32'h0000_3000, 1'b0, 32'h0);

    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_state("post_reset", 32'h0000_3000, 1'b0, 32'h0);

    for (int i = 0; i < 28; i++) begin
      exp_t e;
      if (i != 0) @(negedge clk);
      d_ready        = tbl[i].dr;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      flush          = tbl[i].fl;
      e.idx  = i;
      e.addr = tbl[i].e_addr;
      e.v    = tbl[i].e_v;
      e.pc   = tbl[i].e_pc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: got empty queue expected entry for vector %0d", i);
      end else begin
        e = sb.pop_front();
        check_state($sformatf("vec%0d", e.idx), e.addr, e.v, e.pc);
      end
    end

    // Park a redirect during a stall, then reset before it can be taken.
    @(negedge clk);
    d_ready        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3500;
    flush          = 1'b0;
    @(posedge clk);
    #1;
    check_state("stall_pend", 32'h0000_7004, 1'b1, 32'h0000_7000);
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2;
    reset_n = 1'b0;
    #1;
    check_state("async_reset", 32'h0000_3000, 1'b0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    d_ready = 1'b1;
    @(posedge clk);
    #1;
    check_state("pend_lost", 32'h0000_3004, 1'b1, 32'h0000_3000);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_state("pend_lost2", 32'h0000_3008, 1'b1, 32'h0000_3004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
